// File: rtl/mem_port_arbiter.sv
// Three-way arbiter for the unified Memory port: CPU (0), display fetcher (1),
// keyboard writer (2). Fixed priority 0 > 1 > 2 with starvation promotion of ports 1/2.
module mem_port_arbiter #(
  parameter int unsigned AW           = 32,
  parameter int unsigned DW           = 32,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          we0,
  input  logic          byte0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic          byte1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  input  logic          req2,
  input  logic          we2,
  input  logic          byte2,
  input  logic [AW-1:0] addr2,
  input  logic [DW-1:0] wdata2,
  output logic          gnt0,
  output logic          gnt1,
  output logic          gnt2,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic          rvalid2,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic [DW-1:0] rdata2,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic          mem_byte,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [1:0]    owner
);

  localparam int unsigned NP = 3;
  localparam int unsigned CW = 8;
  localparam logic [CW-1:0] LIMIT   = CW'(STARVE_LIMIT);
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
  localparam logic [1:0]    NO_OWNER = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RDATA  = 2'd2
  } state_e;

  typedef struct packed {
    logic          we;
    logic          bsel;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } txn_t;

  state_e          state_q, state_d;
  txn_t            txn_q, txn_d;
  logic [1:0]      port_q, port_d;
  logic            mem_we_q, mem_we_d;
  logic [1:0]      owner_q, owner_d;
  logic [NP-1:0]   rvalid_q, rvalid_d;
  logic [DW-1:0]   rdata_q [NP];
  logic [DW-1:0]   rdata_d [NP];
  logic [CW-1:0]   cnt1_q, cnt1_d;
  logic [CW-1:0]   cnt2_q, cnt2_d;

  logic            win_vld_c;
  logic [1:0]      win_c;
  txn_t            win_txn_c;
  logic [NP-1:0]   gnt_c;

  // Winner selection; starved ports 1/2 jump ahead of the CPU, port 1 first
  always_comb begin
    win_vld_c = req0 | req1 | req2;
    if (req1 && (cnt1_q >= LIMIT))      win_c = 2'd1;
    else if (req2 && (cnt2_q >= LIMIT)) win_c = 2'd2;
    else if (req0)                      win_c = 2'd0;
    else if (req1)                      win_c = 2'd1;
    else                                win_c = 2'd2;

    case (win_c)
      2'd0:    win_txn_c = '{we: we0, bsel: byte0, addr: addr0, wdata: wdata0};
      2'd1:    win_txn_c = '{we: we1, bsel: byte1, addr: addr1, wdata: wdata1};
      default: win_txn_c = '{we: we2, bsel: byte2, addr: addr2, wdata: wdata2};
    endcase
  end

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    txn_d    = txn_q;
    port_d   = port_q;
    mem_we_d = mem_we_q;
    owner_d  = owner_q;
    rvalid_d = '0;
    cnt1_d   = cnt1_q;
    cnt2_d   = cnt2_q;
    gnt_c    = '0;
    for (int unsigned p = 0; p < NP; p++) rdata_d[p] = rdata_q[p];

    case (state_q)
      IDLE: begin
        if (win_vld_c) begin
          gnt_c[win_c] = 1'b1;
          txn_d        = win_txn_c;
          port_d       = win_c;
          mem_we_d     = win_txn_c.we;
          owner_d      = win_c;
          state_d      = ACCESS;
        end
        // Counters only move on IDLE cycles; a lost arbitration ages the request
        if (!req1 || gnt_c[1])    cnt1_d = '0;
        else if (cnt1_q != CNT_MAX) cnt1_d = cnt1_q + CW'(1);
        if (!req2 || gnt_c[2])    cnt2_d = '0;
        else if (cnt2_q != CNT_MAX) cnt2_d = cnt2_q + CW'(1);
      end
      ACCESS: begin
        mem_we_d = 1'b0;
        if (txn_q.we) begin
          owner_d = NO_OWNER;
          state_d = IDLE;
        end else begin
          state_d = RDATA;
        end
      end
      RDATA: begin
        owner_d = NO_OWNER;
        state_d = IDLE;
        for (int unsigned p = 0; p < NP; p++) begin
          if (2'(p) == port_q) begin
            rvalid_d[p] = 1'b1;
            rdata_d[p]  = mem_rdata;
          end
        end
      end
      default: begin
        mem_we_d = 1'b0;
        owner_d  = NO_OWNER;
        state_d  = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      txn_q    <= '0;
      port_q   <= '0;
      mem_we_q <= 1'b0;
      owner_q  <= NO_OWNER;
      rvalid_q <= '0;
      cnt1_q   <= '0;
      cnt2_q   <= '0;
      for (int unsigned p = 0; p < NP; p++) rdata_q[p] <= '0;
    end else begin
      state_q  <= state_d;
      txn_q    <= txn_d;
      port_q   <= port_d;
      mem_we_q <= mem_we_d;
      owner_q  <= owner_d;
      rvalid_q <= rvalid_d;
      cnt1_q   <= cnt1_d;
      cnt2_q   <= cnt2_d;
      for (int unsigned p = 0; p < NP; p++) rdata_q[p] <= rdata_d[p];
    end
  end

  assign gnt0      = gnt_c[0];
  assign gnt1      = gnt_c[1];
  assign gnt2      = gnt_c[2];
  assign rvalid0   = rvalid_q[0];
  assign rvalid1   = rvalid_q[1];
  assign rvalid2   = rvalid_q[2];
  assign rdata0    = rdata_q[0];
  assign rdata1    = rdata_q[1];
  assign rdata2    = rdata_q[2];
  assign mem_addr  = txn_q.addr;
  assign mem_byte  = txn_q.bsel;
  assign mem_wdata = txn_q.wdata;
  assign mem_we    = mem_we_q;
  assign owner     = owner_q;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified Memory port between three requesters: CPU multicycle datapath (port 0), display fetcher (port 1) and keyboard writer (port 2).
- Sits between the requesters and Memory, and owns mem_addr, mem_we, mem_byte and mem_wdata.
- Uses fixed priority CPU > display > keyboard, with starvation promotion so the display and keyboard ports always make progress.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- STARVE_LIMIT, 8, lost arbitrations before a port-1/2 request is promoted above the CPU (range 1..255).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- reqN  in  1  transaction request, N = 0, 1, 2.
- weN  in  1  1 = write, 0 = read.
- byteN  in  1  byte-wide access.
- addrN  in  AW  address.
- wdataN  in  DW  write data.
- gntN  out  1  one-cycle pulse; the request was accepted this cycle.
- rvalidN  out  1  one-cycle pulse; rdataN holds read data.
- rdataN  out  DW  last read data returned to port N.
- mem_addr  out  AW  Memory address.
- mem_we  out  1  Memory write enable.
- mem_byte  out  1  Memory byte-access select.
- mem_wdata  out  DW  Memory write data.
- mem_rdata  in  DW  Memory read data; synchronous, valid the cycle after the address is presented.
- owner  out  2  port occupying the Memory; 3 = none.

Behaviour:
- Reset values (reset low): state = IDLE, all gntN/rvalidN = 0, rdataN = 0, mem_we = 0, mem_byte = 0, mem_addr = 0, mem_wdata = 0, owner = 3, starvation counters = 0.
- Reset is asynchronous: mem_we drops immediately. An in-flight write is aborted; an in-flight read produces no rvalid.
- FSM states: IDLE, ACCESS, RDATA.
- IDLE, one or more reqN high:
  - Choose winner W (rules below); gntW = 1 combinationally in that cycle.
  - At the clock edge, latch addrW, weW, byteW, wdataW and W; go to ACCESS.
- IDLE, no request: stay in IDLE, owner = 3.
- ACCESS:
  - mem_addr, mem_byte and mem_wdata come from the latched values; mem_we = latched we; owner = W.
  - Next state: RDATA if read, IDLE if write.
  - Write occupancy is 2 cycles (gnt cycle + ACCESS).
- RDATA:
  - mem_we = 0, mem_addr held; owner = W.
  - At the edge, rdataW <= mem_rdata and rvalidW is set for exactly the next cycle; state returns to IDLE.
- Read latency: gnt in cycle T gives rvalid and valid rdata in cycle T+3.
- rdataN holds its value until the next read completes on port N; other ports' rdata are untouched.
- Grants are issued only in IDLE. Requests arriving in ACCESS/RDATA wait, with no gnt.
- A new grant can be issued in the same cycle that rvalid of the previous read is high, so back-to-back reads run every 3 cycles and back-to-back writes every 2.
- Requester rule: reqN, addrN, weN, byteN and wdataN are held stable until gntN. After gntN they may change freely.
- Dropping reqN before grant is legal; no transaction results.
- Arbitration, in order:
  - (a) port 1 if cnt1 >= STARVE_LIMIT;
  - (b) port 2 if cnt2 >= STARVE_LIMIT;
  - (c) port 0;
  - (d) port 1;
  - (e) port 2.
  - Both ports starved: port 1 wins.
- Starvation counter cntN (N = 1, 2, 8 bits, saturating at 255):
  - +1 on every IDLE cycle where reqN = 1 and another port is granted.
  - Cleared on gntN, or when reqN = 0.
  - Not changed in ACCESS/RDATA.
- Write with byte = 1: mem_wdata and mem_byte are passed through unmodified; lane handling is the Memory's responsibility.
- Exactly one gnt per IDLE cycle at most; gntN never asserts outside IDLE.

Test Plan:
- Reset low mid-RDATA of a port-0 read: mem_we = 0 and owner = 3 immediately. After release, rvalid0 never pulses, rdata0 = 0, state = IDLE.
- Single read: req0, addr0 = 0x2580, mem returns 0xDEADBEEF → gnt0 at T, mem_addr = 0x2580 at T+1, rvalid0 = 1 with rdata0 = 0xDEADBEEF at T+3, owner = 0 at T+1..T+2.
- Single write: req2, we2 = 1, addr2 = 0x100, wdata2 = 0x41 → gnt2 at T, mem_we = 1 only at T+1, next grant possible at T+2, no rvalid2.
- Simultaneous req0 + req1 (reads), all held continuously → port 0 granted at T, T+3, ... The 8th lost arbitration sets cnt1 = 8, so the next IDLE grants port 1 despite req0; cnt1 then returns to 0.
- req1 and req2 both starved (cnt = STARVE_LIMIT) with req0 high → gnt1 first, then on the next IDLE gnt2 (cnt2 still >= limit), then port 0.
- req1 raised during a port-0 ACCESS, then dropped before IDLE → no gnt1 and no memory cycle for port 1; cnt1 stays 0.
